// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
// Holds the state encoding, the next-PC select encoding and the word-alignment check.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    NPC_TRAP  = 3'd0,
    NPC_MRET  = 3'd1,
    NPC_REDIR = 3'd2,
    NPC_SEQ   = 3'd3,
    NPC_HOLD  = 3'd4
  } npc_sel_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_hold.sv
// Buffers a branch/jump target that arrives during a stall until the pipeline advances.
// Misaligned targets are dropped here and reported as a one-cycle pulse.
module pc_redirect_hold #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            pc_write,
  input  logic            flush,
  output logic            live_valid,
  output logic            pending,
  output logic [XLEN-1:0] pending_addr,
  output logic            misaligned
);
  import pc_pkg::*;

  logic            aligned;
  logic            pending_reg;
  logic [XLEN-1:0] pending_addr_reg;
  logic            misaligned_reg;

  assign aligned    = is_word_aligned(redirect_addr[1:0]);
  assign live_valid = enable && redirect_valid && aligned;

  // Flush beats everything; an advancing edge consumes (or supersedes) the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg      <= 1'b0;
      pending_addr_reg <= '0;
      misaligned_reg   <= 1'b0;
    end else begin
      misaligned_reg <= enable && redirect_valid && !aligned;
      if (flush) begin
        pending_reg <= 1'b0;
      end else if (enable && pc_write) begin
        pending_reg <= 1'b0;
      end else if (live_valid) begin
        pending_reg      <= 1'b1;
        pending_addr_reg <= redirect_addr;
      end
    end
  end

  assign pending      = pending_reg;
  assign pending_addr = pending_addr_reg;
  assign misaligned   = misaligned_reg;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot/run/halt control, prioritised next-PC selection and
// the fetch/decode PC registers.
module pc_unit #(
  parameter int                 XLEN         = 32,
  parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
  parameter int                 STEP         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mepc,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_prev,
  output logic            redirect_misaligned,
  output logic            redirect_pending
);
  import pc_pkg::*;

  pc_state_e       state_reg;
  pc_state_e       state_next;
  npc_sel_e        npc_sel;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_prev_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pend_addr;
  logic            in_run;
  logic            in_halt;
  logic            flush;
  logic            live_valid;
  logic            pend;

  assign in_run  = (state_reg == ST_RUN);
  assign in_halt = (state_reg == ST_HALT);
  assign flush   = (in_run && (trap_valid || mret_valid)) || (in_halt && trap_valid);

  pc_redirect_hold #(
    .XLEN(XLEN)
  ) u_hold (
    .clk           (clk),
    .rst           (rst),
    .enable        (in_run),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .pc_write      (pc_write),
    .flush         (flush),
    .live_valid    (live_valid),
    .pending       (pend),
    .pending_addr  (pend_addr),
    .misaligned    (redirect_misaligned)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a trap or mret in the same cycle cancels a halt request.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (halt_req && !trap_valid && !mret_valid) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (trap_valid || resume) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // Output decode: fetch qualifier and next-PC source
  always_comb begin
    pc_valid = in_run;
    npc_sel  = NPC_HOLD;
    if (in_run) begin
      if (trap_valid) begin
        npc_sel = NPC_TRAP;
      end else if (mret_valid) begin
        npc_sel = NPC_MRET;
      end else if (pc_write && (live_valid || pend)) begin
        npc_sel = NPC_REDIR;
      end else if (pc_write) begin
        npc_sel = NPC_SEQ;
      end
    end else if (in_halt && trap_valid) begin
      npc_sel = NPC_TRAP;
    end
  end

  // A live redirect is newer than anything buffered, so it takes precedence.
  assign redirect_target = live_valid ? redirect_addr : pend_addr;

  always_comb begin
    pc_next = pc_reg;
    case (npc_sel)
      NPC_TRAP:  pc_next = trap_vector;
      NPC_MRET:  pc_next = mepc;
      NPC_REDIR: pc_next = redirect_target;
      NPC_SEQ:   pc_next = pc_reg + XLEN'(STEP);
      default:   pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RESET_VECTOR;
      pc_prev_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= pc_next;
      if (in_run && (pc_next != pc_reg)) begin
        pc_prev_reg <= pc_reg;
      end
    end
  end

  assign pc               = pc_reg;
  assign pc_prev          = pc_prev_reg;
  assign redirect_pending = pend;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, reset corner sequences, then
// randomized traffic against a rule-level reference model.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        mret_valid;
  logic [31:0] mepc;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_prev;
  logic        redirect_misaligned;
  logic        redirect_pending;

  int tests = 0;
  int fails = 0;

  pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0),
    .STEP(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pc_write           (pc_write),
    .redirect_valid     (redirect_valid),
    .redirect_addr      (redirect_addr),
    .trap_valid         (trap_valid),
    .trap_vector        (trap_vector),
    .mret_valid         (mret_valid),
    .mepc               (mepc),
    .halt_req           (halt_req),
    .resume             (resume),
    .pc                 (pc),
    .pc_valid           (pc_valid),
    .pc_prev            (pc_prev),
    .redirect_misaligned(redirect_misaligned),
    .redirect_pending   (redirect_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          pw;
    int          rv;
    logic [31:0] ra;
    int          tv;
    logic [31:0] tvec;
    int          mr;
    logic [31:0] mepc_v;
    int          halt;
    int          res;
    logic [31:0] e_pc;
    logic [31:0] e_prev;
    int          e_valid;
    int          e_pend;
    int          e_mis;
  } vec_t;

  vec_t vecs[$];

  // Reference model state, expressed in terms of the documented rules.
  bit          m_booted;
  bit          m_halted;
  bit          m_pend;
  bit          m_mis;
  logic [31:0] m_pend_addr;
  logic [31:0] m_pc;
  logic [31:0] m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_prev,
                           input int e_valid, input int e_pend, input int e_mis);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".pc_prev"}, pc_prev, e_prev);
    check({tag, ".pc_valid"}, 32'(pc_valid), 32'(e_valid));
    check({tag, ".pending"}, 32'(redirect_pending), 32'(e_pend));
    check({tag, ".misaligned"}, 32'(redirect_misaligned), 32'(e_mis));
    $display("[TB] %s pc=%h prev=%h valid=%0d pend=%0d mis=%0d", tag, pc, pc_prev,
             pc_valid, redirect_pending, redirect_misaligned);
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_pc, m_prev, int'(m_halted || !m_booted ? 0 : 1), int'(m_pend), int'(m_mis));
  endtask

  task automatic clear_inputs();
    pc_write       = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    trap_valid     = 1'b0;
    trap_vector    = 32'h0;
    mret_valid     = 1'b0;
    mepc           = 32'h0;
    halt_req       = 1'b0;
    resume         = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    pc_write       = (v.pw != 0);
    redirect_valid = (v.rv != 0);
    redirect_addr  = v.ra;
    trap_valid     = (v.tv != 0);
    trap_vector    = v.tvec;
    mret_valid     = (v.mr != 0);
    mepc           = v.mepc_v;
    halt_req       = (v.halt != 0);
    resume         = (v.res != 0);
  endtask

  task automatic model_reset();
    m_booted    = 1'b0;
    m_halted    = 1'b0;
    m_pend      = 1'b0;
    m_mis       = 1'b0;
    m_pend_addr = 32'h0;
    m_pc        = 32'h0;
    m_prev      = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] old_pc;
    bit          live;
    bit          mis_n;
    if (!m_booted) begin
      m_booted = 1'b1;
      m_mis    = 1'b0;
      return;
    end
    mis_n = !m_halted && redirect_valid && (redirect_addr[1:0] != 2'b00);
    if (m_halted) begin
      if (trap_valid) begin
        m_pc     = trap_vector;
        m_pend   = 1'b0;
        m_halted = 1'b0;
      end else if (resume) begin
        m_halted = 1'b0;
      end
    end else begin
      old_pc = m_pc;
      live   = redirect_valid && (redirect_addr[1:0] == 2'b00);
      if (trap_valid) begin
        m_pc   = trap_vector;
        m_pend = 1'b0;
      end else if (mret_valid) begin
        m_pc   = mepc;
        m_pend = 1'b0;
      end else if (pc_write) begin
        if (live) m_pc = redirect_addr;
        else if (m_pend) m_pc = m_pend_addr;
        else m_pc = m_pc + 32'd4;
        m_pend = 1'b0;
      end else if (live) begin
        m_pend      = 1'b1;
        m_pend_addr = redirect_addr;
      end
      if (m_pc != old_pc) m_prev = old_pc;
      if (halt_req && !trap_valid && !mret_valid) m_halted = 1'b1;
    end
    m_mis = mis_n;
  endtask

  initial begin
    vec_t v;
    // pw rv ra tv tvec mr mepc halt res | pc prev valid pend mis
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0004, 32'h0000_0000, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0008, 32'h0000_0004, 1, 0, 0});
    vecs.push_back('{0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0008, 32'h0000_0004, 1, 1, 0});
    vecs.push_back('{0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0008, 32'h0000_0004, 1, 1, 0});
    vecs.push_back('{0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0008, 32'h0000_0004, 1, 1, 0});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0100, 32'h0000_0008, 1, 0, 0});
    vecs.push_back('{1, 1, 32'h102, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0104, 32'h0000_0100, 1, 0, 1});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0108, 32'h0000_0104, 1, 0, 0});
    vecs.push_back('{0, 1, 32'h300, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0108, 32'h0000_0104, 1, 1, 0});
    vecs.push_back('{0, 1, 32'h300, 1, 32'h80, 1, 32'h200, 0, 0, 32'h0000_0080, 32'h0000_0108, 1, 0, 0});
    vecs.push_back('{1, 1, 32'h0C, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_000C, 32'h0000_0080, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0010, 32'h0000_000C, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0000_0010, 32'h0000_000C, 0, 0, 0});
    vecs.push_back('{1, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0010, 32'h0000_000C, 0, 0, 0});
    vecs.push_back('{0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0000_0010, 32'h0000_000C, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0000_0014, 32'h0000_0010, 0, 0, 0});
    vecs.push_back('{0, 0, 32'h0, 1, 32'h80, 0, 32'h0, 0, 0, 32'h0000_0080, 32'h0000_0010, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h0, 1, 32'h200, 0, 32'h0, 1, 0, 32'h0000_0200, 32'h0000_0080, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 1, 32'h1002, 0, 0, 32'h0000_1002, 32'h0000_0200, 1, 0, 0});
    vecs.push_back('{1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 32'hFFFF_FFFC, 32'h0000_1002, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0004, 32'h0000_0000, 1, 0, 0});
    vecs.push_back('{0, 1, 32'h500, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0000_0004, 32'h0000_0000, 1, 1, 0});

    clear_inputs();
    pc_write = 1'b1;
    rst = 1'b1;
    model_reset();
    #2;
    check_all("reset", 32'h0, 32'h0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("boot_hold", 32'h0, 32'h0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      @(posedge clk);
      model_edge();
      #1;
      check_all($sformatf("vec%0d", i), v.e_pc, v.e_prev, v.e_valid, v.e_pend, v.e_mis);
    end

    // Asynchronous reset mid-stall with a redirect buffered.
    rst = 1'b1;
    model_reset();
    #1;
    check_all("mid_reset", 32'h0, 32'h0, 0, 0, 0);
    #2;
    rst = 1'b0;

    // The BOOT-to-RUN edge ignores trap and redirect requests.
    clear_inputs();
    pc_write       = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h300;
    trap_valid     = 1'b1;
    trap_vector    = 32'h80;
    @(posedge clk);
    model_edge();
    #1;
    check_all("boot_ignore", 32'h0, 32'h0, 1, 0, 0);
    clear_inputs();
    pc_write = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    check_all("first_step", 32'h4, 32'h0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_model("rnd_reset");
        #1;
        rst = 1'b0;
      end else begin
        pc_write       = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 3) == 0);
        redirect_addr  = $urandom & 32'h0000_0FFF;
        if ($urandom_range(0, 7) == 0) redirect_addr = redirect_addr | 32'hFFFF_F000;
        if ($urandom_range(0, 3) != 0) redirect_addr[1:0] = 2'b00;
        trap_valid     = ($urandom_range(0, 29) == 0);
        trap_vector    = $urandom & 32'h0000_FFFC;
        mret_valid     = ($urandom_range(0, 29) == 0);
        mepc           = $urandom & 32'h0000_FFFF;
        halt_req       = ($urandom_range(0, 24) == 0);
        resume         = ($urandom_range(0, 4) == 0);
        @(posedge clk);
        model_edge();
        #1;
        check_model($sformatf("rnd%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the scpu datapath. It holds the fetch address, selects the next address by fixed priority (trap, trap-return, branch/jump redirect, sequential step), and buffers a redirect that arrives while the pipeline is stalled. An explicit boot/halt state machine replaces the offset-reset trick, so the first valid fetch is exactly `RESET_VECTOR`. It sits between the control/CSR logic and instruction fetch.

## Interface
- `XLEN`, 32, address width in bits.
- `RESET_VECTOR`, 0, first fetch address after reset (XLEN bits, must be 4-byte aligned).
- `STEP`, 4, sequential increment in bytes.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `pc_write` input 1: advance enable; 0 = stall, hold `pc`.
- `redirect_valid` input 1: branch/jump taken this cycle.
- `redirect_addr` input XLEN: redirect target.
- `trap_valid` input 1: exception/interrupt entry.
- `trap_vector` input XLEN: trap entry address (mtvec).
- `mret_valid` input 1: trap return.
- `mepc` input XLEN: trap return address.
- `halt_req` input 1: request to stop fetching.
- `resume` input 1: leave HALT.
- `pc` output XLEN: current fetch address.
- `pc_valid` output 1: `pc` is a fetch the pipeline must execute.
- `pc_prev` output XLEN: address of the previous accepted fetch (decode-stage PC).
- `redirect_misaligned` output 1: one-cycle pulse; rejected redirect target.
- `redirect_pending` output 1: a buffered redirect is waiting.

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on `rst`. `pc_valid`=0. The first rising edge after `rst` deasserts moves to RUN. `pc` stays `RESET_VECTOR`.
- RUN: `pc_valid`=1. Next-PC priority is trap_valid > mret_valid > redirect (live or pending) > sequential (`pc`+STEP).
- Trap and mret are taken at the next edge regardless of `pc_write`. Either one clears any pending redirect.
- A redirect or sequential step updates `pc` only when `pc_write`=1.
- When `redirect_valid`=1 and `pc_write`=0: latch `redirect_addr` into the pending register and set `redirect_pending`=1.
- Pending redirect is applied on the first later edge with `pc_write`=1, then cleared.
- A new live redirect overwrites the pending one. The newest redirect always wins.
- Misalignment: if `redirect_addr[1:0]`≠0, the redirect is ignored (not applied, not buffered). `redirect_misaligned` pulses for one cycle. The trap is raised by the control logic, not here.
- Misaligned `trap_vector` or `mepc` is used as given, with no check.
- Arithmetic: `pc`+STEP is modulo 2^XLEN. All-ones-minus-3 steps to 0.
- `pc_prev` loads the old `pc` on every edge where `pc` changes while in RUN.
- HALT: entered from RUN when `halt_req`=1 and no trap/mret is active. The `pc` update for that edge still happens.
  - In HALT, `pc_valid`=0, `pc` is held, and `pc_write` and redirects are ignored.
  - `trap_valid` in HALT loads `trap_vector` and returns to RUN (interrupt wake).
  - `resume` returns to RUN with `pc` unchanged.
- `halt_req` and `trap_valid` in the same RUN cycle: the trap wins and the state stays RUN.

## Timing
- Reset values:
  - `pc`=RESET_VECTOR, `pc_prev`=RESET_VECTOR, `pc_valid`=0.
  - `redirect_pending`=0, `redirect_misaligned`=0, state=BOOT.
- All outputs are registered except `pc_valid`, which is decoded from state.
- One-cycle redirect latency: target is asserted at edge N, and `pc` equals the target after edge N.
- Reset asserted mid-operation clears everything immediately (async), including the pending redirect and HALT.
- A BOOT-to-RUN edge with `redirect_valid`/`trap_valid` high ignores them. The first fetch is always `RESET_VECTOR`.

## Structure
- `pc_pkg`: state enum (BOOT/RUN/HALT), `NPC_SEL` encoding (TRAP/MRET/REDIR/SEQ), alignment-mask constant.
- Sub-module `pc_redirect_hold`: pending-redirect register with set/overwrite/consume/clear and misalignment check.
- Top: next-PC mux, state machine, `pc`/`pc_prev` registers.

## Test plan
- Reset release with `pc_write`=1 and `RESET_VECTOR`=0x0: cycle 0 shows `pc_valid`=0. Then `pc` shows 0x0, 0x4, 0x8 on successive edges and `pc_prev` lags by one.
- Redirect to 0x100 with `pc_write`=0 for 3 cycles: `redirect_pending`=1 and `pc` is held. When `pc_write` goes to 1, `pc`=0x100 at the next edge and pending clears.
- Redirect to 0x102: `pc` steps sequentially, `redirect_misaligned` pulses for exactly 1 cycle, and `redirect_pending`=0.
- Same cycle trap (vector 0x80), mret (0x200) and redirect (0x300) with `pc_write`=0: `pc`=0x80 and pending is cleared.
- `halt_req` at `pc`=0x10:
  - `pc_valid` goes to 0 and `pc` holds.
  - `resume` brings back `pc_valid`=1 at the same `pc`.
  - Halting again, then `trap_valid` with vector 0x80, gives RUN with `pc`=0x80.
- `pc`=0xFFFFFFFC with a step: `pc`=0x0. `rst` asserted mid-stall with a pending redirect: `pc`=RESET_VECTOR immediately and pending=0.
